// File: rtl/core_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : core_instr_queue
// Purpose  : In-order fetch-to-decode instruction queue that pairs snooped AR
//            addresses with R beats and drops stale beats after a flush.
// Revision : 1.0 - initial release
// ============================================================================
module core_instr_queue #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic [ADDR_WIDTH-1:0]  ARADDR,
    input  logic [INSTR_WIDTH-1:0] RDATA,
    input  logic                   RVALID,
    output logic                   RREADY,
    output logic                   fetch_stall,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   decode_ready,
    output logic                   overflow
);

    localparam int C_PTR_W  = $clog2(DEPTH);
    localparam int C_DISC_W = CNT_W + 1;
    localparam int C_SUM_W  = C_DISC_W + 1;
    localparam logic [C_DISC_W-1:0] C_DISC_MAX  = C_DISC_W'(DEPTH + 1);
    localparam logic [CNT_W-1:0]    C_FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]    C_STALL_LVL = CNT_W'(DEPTH - 1);

    // Entry storage
    logic [ADDR_WIDTH-1:0]  pc_q     [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_d     [DEPTH];
    logic [INSTR_WIDTH-1:0] data_q   [DEPTH];
    logic [INSTR_WIDTH-1:0] data_d   [DEPTH];
    logic [DEPTH-1:0]       filled_q;
    logic [DEPTH-1:0]       filled_d;

    // Pointers and counters
    logic [C_PTR_W-1:0]  alloc_ptr_q,   alloc_ptr_d;
    logic [C_PTR_W-1:0]  fill_ptr_q,    fill_ptr_d;
    logic [C_PTR_W-1:0]  head_ptr_q,    head_ptr_d;
    logic [CNT_W-1:0]    alloc_cnt_q,   alloc_cnt_d;
    logic [CNT_W-1:0]    pend_cnt_q,    pend_cnt_d;
    logic [C_DISC_W-1:0] discard_cnt_q, discard_cnt_d;
    logic                overflow_q,    overflow_d;

    logic               w_ar_fire;
    logic               w_r_fire;
    logic               w_head_valid;
    logic               w_pop;
    logic               w_full;
    logic               w_alloc;
    logic               w_fill;
    logic               w_drop;
    logic [C_SUM_W-1:0] w_disc_sum;

    always_comb begin
        w_ar_fire    = ARVALID & ARREADY;
        w_r_fire     = RVALID & RREADY;
        w_head_valid = (alloc_cnt_q != '0) & filled_q[head_ptr_q];
        w_pop        = w_head_valid & decode_ready & ~flush;
        w_full       = (alloc_cnt_q == C_FULL);
        w_alloc      = w_ar_fire & ~flush & (~w_full | w_pop);
        w_fill       = w_r_fire & ~flush & (discard_cnt_q == '0);
        w_drop       = w_r_fire & ~flush & (discard_cnt_q != '0);
        // Everything allocated-but-unfilled at flush time, plus an AR landing
        // in the flush cycle, will still produce a beat that must be dropped.
        w_disc_sum   = C_SUM_W'(discard_cnt_q) + C_SUM_W'(pend_cnt_q)
                     + C_SUM_W'(w_ar_fire) - C_SUM_W'(w_r_fire);
    end

    always_comb begin
        pc_d          = pc_q;
        data_d        = data_q;
        filled_d      = filled_q;
        alloc_ptr_d   = alloc_ptr_q;
        fill_ptr_d    = fill_ptr_q;
        head_ptr_d    = head_ptr_q;
        alloc_cnt_d   = alloc_cnt_q;
        pend_cnt_d    = pend_cnt_q;
        discard_cnt_d = discard_cnt_q;
        overflow_d    = overflow_q;

        if (w_ar_fire & ~flush & w_full & ~w_pop) begin
            overflow_d = 1'b1;
        end

        if (flush) begin
            filled_d      = '0;
            alloc_ptr_d   = '0;
            fill_ptr_d    = '0;
            head_ptr_d    = '0;
            alloc_cnt_d   = '0;
            pend_cnt_d    = '0;
            discard_cnt_d = (w_disc_sum > C_SUM_W'(C_DISC_MAX)) ? C_DISC_MAX
                                                                : C_DISC_W'(w_disc_sum);
        end else begin
            if (w_pop) begin
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d           = head_ptr_q + 1'b1;
            end
            if (w_fill) begin
                data_d[fill_ptr_q]   = RDATA;
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + 1'b1;
            end
            // When full, alloc only happens alongside a pop of the same slot,
            // so this write intentionally lands after the pop clear.
            if (w_alloc) begin
                pc_d[alloc_ptr_q]     = ARADDR;
                filled_d[alloc_ptr_q] = 1'b0;
                alloc_ptr_d           = alloc_ptr_q + 1'b1;
            end
            if (w_drop) begin
                discard_cnt_d = discard_cnt_q - 1'b1;
            end

            unique case ({w_alloc, w_pop})
                2'b10:   alloc_cnt_d = alloc_cnt_q + 1'b1;
                2'b01:   alloc_cnt_d = alloc_cnt_q - 1'b1;
                default: alloc_cnt_d = alloc_cnt_q;
            endcase

            unique case ({w_alloc, w_fill})
                2'b10:   pend_cnt_d = pend_cnt_q + 1'b1;
                2'b01:   pend_cnt_d = pend_cnt_q - 1'b1;
                default: pend_cnt_d = pend_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
            filled_q      <= '0;
            alloc_ptr_q   <= '0;
            fill_ptr_q    <= '0;
            head_ptr_q    <= '0;
            alloc_cnt_q   <= '0;
            pend_cnt_q    <= '0;
            discard_cnt_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= pc_d[i];
                data_q[i] <= data_d[i];
            end
            filled_q      <= filled_d;
            alloc_ptr_q   <= alloc_ptr_d;
            fill_ptr_q    <= fill_ptr_d;
            head_ptr_q    <= head_ptr_d;
            alloc_cnt_q   <= alloc_cnt_d;
            pend_cnt_q    <= pend_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        RREADY      = (pend_cnt_q != '0) | (discard_cnt_q != '0);
        fetch_stall = (alloc_cnt_q >= C_STALL_LVL) | flush;
        instr_valid = w_head_valid;
        instr       = w_head_valid ? data_q[head_ptr_q] : '0;
        instr_pc    = w_head_valid ? pc_q[head_ptr_q]   : '0;
        overflow    = overflow_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_core_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_instr_queue
// Purpose  : Directed self-checking bench for core_instr_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_instr_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        RREADY;
    logic        fetch_stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready;
    logic        overflow;

    int n_vec = 0;
    int n_bad = 0;

    core_instr_queue #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .DEPTH      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .ARADDR      (ARADDR),
        .RDATA       (RDATA),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .fetch_stall (fetch_stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .decode_ready(decode_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
        chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
        chk({tag, "_pc"},    64'(instr_pc),    64'(pc));
        chk({tag, "_instr"}, 64'(instr),       64'(data));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"},    64'(instr_valid), 64'd0);
        chk({tag, "_instr"},    64'(instr),       64'd0);
        chk({tag, "_pc"},       64'(instr_pc),    64'd0);
        chk({tag, "_rready"},   64'(RREADY),      64'd0);
        chk({tag, "_stall"},    64'(fetch_stall), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow),    64'd0);
    endtask

    // Single fetch + response one cycle later, then pop
    task automatic fetch_one(input string tag, input logic [31:0] pc);
        ARVALID = 1'b1; ARADDR = pc;
        cyc();
        ARVALID = 1'b0;
        RVALID = 1'b1; RDATA = mk(pc);
        cyc();
        RVALID = 1'b0;
        chk_head(tag, pc, mk(pc));
        decode_ready = 1'b1;
        cyc();
        decode_ready = 1'b0;
        chk({tag, "_popped"}, 64'(instr_valid), 64'd0);
    endtask

    logic [31:0] expq[$];
    logic [31:0] rq[$];
    int          sent;
    int          got;
    logic        rfire;

    initial begin
        rst = 1'b1; flush = 1'b0; ARVALID = 1'b0; ARREADY = 1'b1; ARADDR = '0;
        RDATA = '0; RVALID = 1'b0; decode_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk_idle_outputs("reset");

        // Single fetch, response two cycles after the AR
        ARVALID = 1'b1; ARADDR = 32'h0;
        cyc();
        ARVALID = 1'b0;
        cyc();
        RVALID = 1'b1; RDATA = 32'h13;
        #1;
        chk("s1_rready", 64'(RREADY), 64'd1);
        cyc();
        RVALID = 1'b0;
        chk_head("s1_head", 32'h0, 32'h13);
        decode_ready = 1'b1;
        cyc();
        decode_ready = 1'b0;
        chk("s1_pop", 64'(instr_valid), 64'd0);

        // Fill to stall: four ARs, each response the following cycle
        for (int i = 0; i < 5; i++) begin
            ARVALID = (i < 4);
            ARADDR  = 32'(i * 4);
            RVALID  = (i > 0);
            RDATA   = mk(32'((i - 1) * 4));
            cyc();
            chk($sformatf("s2_stall%0d", i), 64'(fetch_stall), 64'(i >= 2));
        end
        ARVALID = 1'b0; RVALID = 1'b0;
        chk("s2_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            decode_ready = 1'b1;
            #1;
            chk_head($sformatf("s2_pop%0d", i), 32'(i * 4), mk(32'(i * 4)));
            cyc();
        end
        decode_ready = 1'b0;
        chk("s2_empty", 64'(instr_valid), 64'd0);
        chk("s2_unstall", 64'(fetch_stall), 64'd0);

        // Flush with two requests outstanding
        ARVALID = 1'b1; ARADDR = 32'h10;
        cyc();
        ARADDR = 32'h14;
        cyc();
        ARVALID = 1'b0; flush = 1'b1;
        #1;
        chk("s3_flush_stall", 64'(fetch_stall), 64'd1);
        cyc();
        flush = 1'b0;
        chk("s3_rready", 64'(RREADY), 64'd1);
        chk("s3_valid0", 64'(instr_valid), 64'd0);
        RVALID = 1'b1; RDATA = 32'hDEAD_0001;
        cyc();
        chk("s3_valid1", 64'(instr_valid), 64'd0);
        chk("s3_rready1", 64'(RREADY), 64'd1);
        RDATA = 32'hDEAD_0002;
        cyc();
        RVALID = 1'b0;
        chk("s3_valid2", 64'(instr_valid), 64'd0);
        chk("s3_rready2", 64'(RREADY), 64'd0);
        fetch_one("s3_new", 32'h100);

        // Flush coinciding with a fresh AR and an R beat
        ARVALID = 1'b1; ARADDR = 32'h1C;
        cyc();
        ARADDR = 32'h40;
        cyc();
        flush = 1'b1; ARADDR = 32'h20; RVALID = 1'b1; RDATA = mk(32'h1C);
        cyc();
        flush = 1'b0; ARVALID = 1'b0; RVALID = 1'b0;
        chk("s4_rready", 64'(RREADY), 64'd1);
        chk("s4_valid0", 64'(instr_valid), 64'd0);
        RVALID = 1'b1; RDATA = 32'hDEAD_0003;
        cyc();
        chk("s4_rready1", 64'(RREADY), 64'd1);
        chk("s4_valid1", 64'(instr_valid), 64'd0);
        cyc();
        RVALID = 1'b0;
        chk("s4_rready2", 64'(RREADY), 64'd0);
        chk("s4_valid2", 64'(instr_valid), 64'd0);
        fetch_one("s4_new", 32'h80);

        // Alloc and pop together at three entries
        for (int i = 0; i < 4; i++) begin
            ARVALID = (i < 3);
            ARADDR  = 32'h300 + 32'(i * 4);
            RVALID  = (i > 0);
            RDATA   = mk(32'h300 + 32'((i - 1) * 4));
            cyc();
        end
        ARVALID = 1'b0; RVALID = 1'b0;
        chk("s5_stall3", 64'(fetch_stall), 64'd1);
        ARVALID = 1'b1; ARADDR = 32'h30C; decode_ready = 1'b1;
        #1;
        chk_head("s5_pop0", 32'h300, mk(32'h300));
        cyc();
        ARVALID = 1'b0; decode_ready = 1'b0;
        chk("s5_stall_kept", 64'(fetch_stall), 64'd1);
        chk("s5_rready", 64'(RREADY), 64'd1);
        RVALID = 1'b1; RDATA = mk(32'h30C);
        cyc();
        RVALID = 1'b0;
        for (int i = 1; i < 4; i++) begin
            decode_ready = 1'b1;
            #1;
            chk_head($sformatf("s5_pop%0d", i), 32'h300 + 32'(i * 4), mk(32'h300 + 32'(i * 4)));
            cyc();
        end
        decode_ready = 1'b0;
        chk("s5_empty", 64'(instr_valid), 64'd0);
        chk("s5_unstall", 64'(fetch_stall), 64'd0);

        // Twelve streaming fetches across pointer wrap, decode_ready toggling
        sent = 0; got = 0;
        for (int c = 0; c < 300 && got < 12; c++) begin
            ARVALID      = (sent < 12) && !fetch_stall;
            ARADDR       = 32'(sent * 4);
            RVALID       = (rq.size() > 0);
            RDATA        = (rq.size() > 0) ? mk(rq[0]) : 32'h0;
            decode_ready = (c % 2 == 0);
            #1;
            rfire = RVALID && RREADY;
            if (instr_valid && decode_ready) begin
                chk($sformatf("wrap_pc%0d", got), 64'(instr_pc), 64'(expq[0]));
                chk($sformatf("wrap_instr%0d", got), 64'(instr), 64'(mk(expq[0])));
                void'(expq.pop_front());
                got++;
            end
            @(posedge clk);
            if (ARVALID) begin
                rq.push_back(ARADDR);
                expq.push_back(ARADDR);
                sent++;
            end
            if (rfire) void'(rq.pop_front());
            #1;
        end
        ARVALID = 1'b0; RVALID = 1'b0; decode_ready = 1'b0;
        chk("wrap_count", 64'(got), 64'd12);
        chk("wrap_overflow", 64'(overflow), 64'd0);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            ARVALID = 1'b1;
            ARADDR  = 32'h400 + 32'(i * 4);
            RVALID  = (i > 0);
            RDATA   = mk(32'h400 + 32'((i - 1) * 4));
            cyc();
        end
        ARVALID = 1'b0; RVALID = 1'b0;
        chk("s7_pre_valid", 64'(instr_valid), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle_outputs("s7_rst");
        fetch_one("s7_after", 32'h500);

        // Overflow: fifth AR while full, no pop
        for (int i = 0; i < 4; i++) begin
            ARVALID = 1'b1; ARADDR = 32'h600 + 32'(i * 4);
            cyc();
        end
        chk("s8_no_ovf", 64'(overflow), 64'd0);
        ARADDR = 32'h610;
        cyc();
        ARVALID = 1'b0;
        chk("s8_ovf", 64'(overflow), 64'd1);
        cyc();
        chk("s8_ovf_sticky", 64'(overflow), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("s8_ovf_rst", 64'(overflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_instr_queue.md
Name: core_instr_queue

Overview:
- In-order instruction queue between the fetch stage and decode.
- Snoops the fetch stage's AXI-lite AR handshakes to record each requested PC, and owns RREADY on the R channel.
- Pairs every R beat with its PC and presents {instr, pc} to decode with a valid/ready handshake.
- On a branch flush it drops queued entries, silently discards read responses still in flight from the old path, and throttles fetch through fetch_stall.

Parameters:
ADDR_WIDTH, 32, PC / ARADDR width (matches core_pkg)
INSTR_WIDTH, 32, instruction width (equals DATA_WIDTH)
DEPTH, 4, queue entries; power of two, minimum 2
CNT_W, $clog2(DEPTH)+1, occupancy / discard counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  branch taken; same cycle as fetch is_branch
ARVALID  in  1  snooped from fetch stage
ARREADY  in  1  snooped from memory
ARADDR  in  ADDR_WIDTH  snooped request address
RDATA  in  INSTR_WIDTH  read data
RVALID  in  1  read data valid
RREADY  out  1  queue accepts read data
fetch_stall  out  1  to fetch stage fetch_stall
instr_valid  out  1  head entry holds instruction
instr  out  INSTR_WIDTH  head instruction; 0 when !instr_valid
instr_pc  out  ADDR_WIDTH  head PC; 0 when !instr_valid
decode_ready  in  1  decode consumes head
overflow  out  1  sticky: AR accepted while queue full

Behaviour:
- Internal events:
  - ar_fire = ARVALID & ARREADY
  - r_fire = RVALID & RREADY
  - pop = instr_valid & decode_ready & !flush
- Storage: DEPTH entries of {pc, data, filled}, plus alloc_ptr, fill_ptr and head_ptr, each wrapping modulo DEPTH. alloc_cnt counts allocated, not-yet-popped entries, 0..DEPTH.
- Allocation:
  - On ar_fire, write the entry at alloc_ptr with pc=ARADDR and filled=0.
  - Increment alloc_ptr and alloc_cnt.
  - If alloc_cnt==DEPTH and pop is not active in the same cycle: do not allocate, and set overflow=1 until reset.
- Fill:
  - On r_fire with discard_cnt==0: write RDATA into the entry at fill_ptr, set filled=1, increment fill_ptr.
  - On r_fire with discard_cnt>0: drop the data and decrement discard_cnt.
  - Responses arrive strictly in request order.
- RREADY: combinational, 1 iff (allocated-unfilled entries > 0) or (discard_cnt > 0).
- Head output:
  - instr_valid = (alloc_cnt>0) & filled[head_ptr], driven from registers.
  - Latency: r_fire in cycle N gives instr_valid=1 in cycle N+1 at the earliest.
  - On pop, increment head_ptr and decrement alloc_cnt.
  - A simultaneous alloc and pop leaves alloc_cnt unchanged.
  - An entry may be filled and popped in consecutive cycles; the queue sustains back-to-back pops.
- fetch_stall:
  - Combinational, = (alloc_cnt >= DEPTH-1) | flush.
  - The DEPTH-1 threshold covers the fetch stage's one-cycle registered ARVALID response, so at most one further AR can fire after stall rises.
- Flush (priority over pop and fill writes):
  - Next cycle: alloc_cnt=0, all filled=0, and all three pointers reset to 0.
  - discard_cnt_next = discard_cnt + (allocated-unfilled entries) + ar_fire − r_fire.
  - An AR accepted in the flush cycle is treated as stale.
  - An R beat in the flush cycle is dropped.
- Reset (synchronous, active-high):
  - Outputs: instr_valid=0, instr=0, instr_pc=0, RREADY=0, fetch_stall=0, overflow=0.
  - State: pointers, counters and discard_cnt all 0.
  - Reset mid-operation abandons in-flight beats without discarding them; the memory side is reset concurrently.
- Counters saturate: discard_cnt never exceeds DEPTH+1. Its width is CNT_W+1 bits.

Test Plan:
- Single fetch: AR pc=0x0000_0000 fires; RDATA=0x0000_0013 returns 2 cycles later -> RREADY=1 that cycle; the next cycle instr_valid=1, instr=0x13, instr_pc=0x0; decode_ready=1 pops, and instr_valid returns to 0.
- Fill to stall: decode_ready=0 and 4 ARs (0x0, 0x4, 0x8, 0xC) with immediate R data -> fetch_stall=1 once alloc_cnt=3; alloc_cnt reaches 4, overflow stays 0; entries pop in order with matching PCs.
- Flush with 2 in flight: ARs 0x10 and 0x14 outstanding, then flush=1 -> discard_cnt=2; the next two R beats are dropped with RREADY=1 and instr_valid=0; an AR 0x100 followed by its R beat then appears as instr_pc=0x100.
- Simultaneous events:
  - flush in the same cycle as ar_fire (0x20) and r_fire for 0x1C, with one older unfilled entry -> discard_cnt=2; no instr_valid until a post-flush fetch completes.
  - alloc and pop in the same cycle with alloc_cnt=3 -> alloc_cnt stays 3.
- Wrap-around: stream 12 sequential fetches, 0x0..0x2C, with decode_ready toggling 1/0 -> all 12 pop in order with correct pc/instr across pointer wrap; overflow=0.
- Reset mid-stream: rst=1 with 3 entries queued -> next cycle all outputs 0, alloc_cnt=0, discard_cnt=0.
